// File: rtl/c906_sysctl_gen.sv
// c906_sysctl_gen: system-control generator beside the C906 core wrapper.
// Produces the prescaled pad_cpu_sys_cnt time base, a divided sys_apb_clk
// with an aligned enable pulse, and conditioned PLIC interrupt inputs.
module c906_sysctl_gen #(
  parameter int unsigned CNT_W       = 64,
  parameter int unsigned PRESCALE_W  = 8,
  parameter int unsigned APB_DIV     = 2,
  parameter int unsigned INT_NUM     = 40,
  parameter int unsigned INT_OUT     = 240,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   pll_core_cpuclk,
  input  logic                   pad_cpu_rst_b,
  input  logic [PRESCALE_W-1:0]  cnt_prescale,
  input  logic                   cnt_halt,
  input  logic                   cnt_load,
  input  logic [CNT_W-1:0]       cnt_load_val,
  output logic [CNT_W-1:0]       pad_cpu_sys_cnt,
  output logic                   sys_apb_clk,
  output logic                   apb_clk_en,
  input  logic [INT_NUM-1:0]     xx_intc_int,
  input  logic [INT_NUM-1:0]     int_edge_mode,
  input  logic [INT_NUM-1:0]     int_clr,
  output logic [INT_OUT-1:0]     pad_plic_int_vld,
  output logic [INT_OUT-1:0]     pad_plic_int_cfg
);

  localparam int unsigned DIV_W = (APB_DIV > 2) ? $clog2(APB_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(APB_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HIGH = DIV_W'(APB_DIV / 2);

  // ---------------------------------------------------------------------
  // Prescaler and system counter
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0]      r_cnt;
  logic [PRESCALE_W-1:0] r_psc;
  logic                  w_tick;

  // ">=" rather than "==" so a prescale value lowered below the current
  // count still produces a tick on the next cycle instead of wrapping.
  assign w_tick = (r_psc >= cnt_prescale);

  // Load beats halt, halt freezes both prescaler and counter.
  always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      r_cnt <= '0;
      r_psc <= '0;
    end else if (cnt_load) begin
      r_cnt <= cnt_load_val;
      r_psc <= '0;
    end else if (!cnt_halt) begin
      if (w_tick) begin
        r_psc <= '0;
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_psc <= r_psc + PRESCALE_W'(1);
      end
    end
  end

  assign pad_cpu_sys_cnt = r_cnt;

  // ---------------------------------------------------------------------
  // APB clock divider
  // ---------------------------------------------------------------------
  logic [DIV_W-1:0] r_div;
  logic             r_apb_clk;
  logic             r_apb_en;

  // Free-running phase counter; clock high for the first APB_DIV/2 phases.
  always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      r_div     <= '0;
      r_apb_clk <= 1'b0;
      r_apb_en  <= 1'b0;
    end else begin
      r_div     <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
      r_apb_clk <= (r_div < DIV_HIGH);
      r_apb_en  <= (r_div == '0);
    end
  end

  assign sys_apb_clk = r_apb_clk;
  assign apb_clk_en  = r_apb_en;

  // ---------------------------------------------------------------------
  // Interrupt conditioning
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][INT_NUM-1:0] r_sync;
  logic [INT_NUM-1:0]                  r_prev;
  logic [INT_NUM-1:0]                  r_pend;
  logic [INT_NUM-1:0]                  w_s;
  logic [INT_NUM-1:0]                  w_rise;
  logic [INT_NUM-1:0]                  w_pend_nxt;

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_rise = w_s & ~r_prev;

  // Edge channels: set beats clear, else hold. Level channels follow w_s,
  // which also discards any sticky state on an edge->level switch.
  always_comb begin
    w_pend_nxt = (int_edge_mode & (w_rise | (r_pend & ~int_clr)))
               | (~int_edge_mode & w_s);
  end

  // Synchroniser chain, previous-sample register and pending bits.
  always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      r_sync <= '0;
      r_prev <= '0;
      r_pend <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], xx_intc_int};
      r_prev <= w_s;
      r_pend <= w_pend_nxt;
    end
  end

  assign pad_plic_int_vld = INT_OUT'(r_pend);
  assign pad_plic_int_cfg = '0;

endmodule

// File: tb/tb_c906_sysctl_gen.sv
// Scoreboard bench for c906_sysctl_gen: directed stimulus pushes the
// hand-computed expected outputs; a monitor pops and compares them.
module tb_c906_sysctl_gen;

  logic         clk = 1'b0;
  logic         rst_b;
  logic [7:0]   prescale;
  logic         halt, load;
  logic [63:0]  load_val;
  logic [39:0]  xx, mode, clr;

  logic [63:0]  cnt0, cnt1;
  logic         apb0, en0, apb1, en1;
  logic [239:0] vld0, cfg0, vld1, cfg1;

  always #5 clk = ~clk;

  c906_sysctl_gen u0 (
    .pll_core_cpuclk (clk),     .pad_cpu_rst_b   (rst_b),
    .cnt_prescale    (prescale), .cnt_halt        (halt),
    .cnt_load        (load),    .cnt_load_val    (load_val),
    .pad_cpu_sys_cnt (cnt0),    .sys_apb_clk     (apb0),
    .apb_clk_en      (en0),     .xx_intc_int     (xx),
    .int_edge_mode   (mode),    .int_clr         (clr),
    .pad_plic_int_vld(vld0),    .pad_plic_int_cfg(cfg0)
  );

  c906_sysctl_gen #(.APB_DIV(5)) u1 (
    .pll_core_cpuclk (clk),     .pad_cpu_rst_b   (rst_b),
    .cnt_prescale    (prescale), .cnt_halt        (halt),
    .cnt_load        (load),    .cnt_load_val    (load_val),
    .pad_cpu_sys_cnt (cnt1),    .sys_apb_clk     (apb1),
    .apb_clk_en      (en1),     .xx_intc_int     (xx),
    .int_edge_mode   (mode),    .int_clr         (clr),
    .pad_plic_int_vld(vld1),    .pad_plic_int_cfg(cfg1)
  );

  typedef struct {
    string        name;
    logic [63:0]  cnt;
    logic         apb, en, apb5, en5;
    logic [239:0] vld;
  } exp_t;

  exp_t q[$];
  event chk_ev;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [239:0] act,
                     input logic [239:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: outputs are presented after every clock edge (and on demand for
  // the asynchronous reset check); compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or chk_ev);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.name, ".cnt"},   240'(cnt0), 240'(e.cnt));
        chk({e.name, ".apb"},   240'(apb0), 240'(e.apb));
        chk({e.name, ".en"},    240'(en0),  240'(e.en));
        chk({e.name, ".vld"},   vld0,       e.vld);
        chk({e.name, ".cfg"},   cfg0,       240'(0));
        chk({e.name, ".cnt5"},  240'(cnt1), 240'(e.cnt));
        chk({e.name, ".apb5"},  240'(apb1), 240'(e.apb5));
        chk({e.name, ".en5"},   240'(en1),  240'(e.en5));
        chk({e.name, ".vld5"},  vld1,       e.vld);
        chk({e.name, ".cfg5"},  cfg1,       240'(0));
      end
    end
  end

  // Stimulus state: expected counter/vector after the next edge, and the
  // number of edges since reset release (drives the divider expectations).
  string        tag;
  logic [63:0]  e_cnt;
  logic [239:0] e_vld;
  int           k;

  task automatic step();
    exp_t e;
    int   kn;
    kn     = k + 1;
    e.name = tag;
    e.cnt  = e_cnt;
    e.vld  = e_vld;
    e.apb  = (kn % 2) == 1;
    e.en   = (kn % 2) == 1;
    e.apb5 = ((kn - 1) % 5) < 2;
    e.en5  = ((kn - 1) % 5) == 0;
    q.push_back(e);
    @(negedge clk);
    k = kn;
  endtask

  task automatic step_rst();
    exp_t e;
    e.name = tag;
    e.cnt = '0; e.vld = '0;
    e.apb = 1'b0; e.en = 1'b0; e.apb5 = 1'b0; e.en5 = 1'b0;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic run();
    e_cnt = e_cnt + 64'd1;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t ea;
    rst_b = 1'b0; prescale = '0; halt = 1'b0; load = 1'b0; load_val = '0;
    xx = '0; mode = '0; clr = '0;
    e_cnt = '0; e_vld = '0; k = 0;
    @(negedge clk);
    tag = "reset";
    repeat (2) step_rst();

    // Scenario 1: free run, prescale 0
    rst_b = 1'b1;
    tag = "run0";
    for (int j = 1; j <= 10; j++) begin e_cnt = 64'(j); step(); end

    // Scenario 2: prescale 3, halt, load with halt, wrap
    tag = "psc3";
    prescale = 8'd3;
    for (int j = 1; j <= 16; j++) begin e_cnt = 64'(10 + j / 4); step(); end
    tag = "halt";
    halt = 1'b1;
    repeat (5) begin e_cnt = 64'd14; step(); end
    tag = "load";
    load = 1'b1; load_val = 64'hFFFF_FFFF_FFFF_FFFE; prescale = 8'd0;
    e_cnt = 64'hFFFF_FFFF_FFFF_FFFE; step();
    load = 1'b0; halt = 1'b0;
    tag = "wrap";
    e_cnt = 64'hFFFF_FFFF_FFFF_FFFF; step();
    e_cnt = 64'd0; step();
    e_cnt = 64'd1; step();

    // Scenario 4: channel 7 level mode, clear ignored
    tag = "lvl7";
    xx[7] = 1'b1;
    run(); run();
    e_vld[7] = 1'b1; run(); run();
    clr[7] = 1'b1; run();
    clr[7] = 1'b0; run();
    xx[7] = 1'b0;
    run(); run();
    e_vld[7] = 1'b0; run(); run();

    // Scenario 5: channel 3 edge mode
    tag = "edge3";
    mode[3] = 1'b1; run();
    xx[3] = 1'b1; run(); run();
    e_vld[3] = 1'b1; run(); run(); run();
    xx[3] = 1'b0; run(); run(); run(); run();
    tag = "clr3";
    clr[3] = 1'b1; e_vld[3] = 1'b0; run();
    clr[3] = 1'b0; run();
    tag = "setwins3";
    xx[3] = 1'b1; run(); run();
    clr[3] = 1'b1; e_vld[3] = 1'b1; run();
    clr[3] = 1'b0; run(); run();
    tag = "clrhigh3";
    clr[3] = 1'b1; e_vld[3] = 1'b0; run();
    clr[3] = 1'b0; run();
    xx[3] = 1'b0; run(); run(); run();

    // Scenario 6: asynchronous reset with interrupts pending
    tag = "prerst";
    xx[7] = 1'b1; xx[3] = 1'b1;
    run(); run();
    e_vld[7] = 1'b1; e_vld[3] = 1'b1; run();
    #2;
    rst_b = 1'b0;
    ea.name = "asyncrst";
    ea.cnt = '0; ea.vld = '0;
    ea.apb = 1'b0; ea.en = 1'b0; ea.apb5 = 1'b0; ea.en5 = 1'b0;
    q.push_back(ea);
    ->chk_ev;
    xx = '0; mode = '0; clr = '0;
    @(negedge clk);
    tag = "reset2";
    repeat (2) step_rst();
    rst_b = 1'b1; k = 0; e_vld = '0;
    tag = "run0b";
    for (int j = 1; j <= 10; j++) begin e_cnt = 64'(j); step(); end

    @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
